mppt_dp: RTL and testbench

- Perturb-and-observe MPPT datapath. Sits directly downstream of the MPPT state decoder `dec` and consumes its `en[3:0]` strobes and `rst_ci`.
- Feeds back `flag_o[1:0]` from an internal interval timer, which closes the loop with the decoder.
- Samples panel voltage and current, computes power, and decides the perturbation direction.
- Drives the converter duty-cycle word.

---
 rtl/mppt_pkg.sv | 30 +++
 rtl/mppt_timer.sv | 38 +++
 rtl/mppt_dp.sv | 123 ++++++++++++
 tb/tb_mppt_dp.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mppt_pkg.sv
// Shared constants for the MPPT decoder/datapath pair: strobe and flag bit
// positions plus default widths, timer thresholds and duty limits.
package mppt_pkg;

  // Bit positions inside the en[3:0] strobe word from the decoder.
  localparam int unsigned EN_SAMPLE = 0;
  localparam int unsigned EN_POWER  = 1;
  localparam int unsigned EN_DECIDE = 2;
  localparam int unsigned EN_UPDATE = 3;

  // Bit positions inside flag_o[1:0] fed back to the decoder.
  localparam int unsigned FLAG_START  = 0;
  localparam int unsigned FLAG_PERIOD = 1;

  // Default widths.
  localparam int unsigned DEF_W_ADC  = 12;
  localparam int unsigned DEF_W_DUTY = 10;
  localparam int unsigned DEF_W_CNT  = 16;

  // Default interval timer thresholds.
  localparam int unsigned DEF_T_START  = 8;
  localparam int unsigned DEF_T_PERIOD = 100;

  // Default duty-cycle limits.
  localparam int unsigned DEF_DUTY_INIT = 512;
  localparam int unsigned DEF_DUTY_MIN  = 64;
  localparam int unsigned DEF_DUTY_MAX  = 960;
  localparam int unsigned DEF_DUTY_STEP = 4;

endpackage

// File: rtl/mppt_timer.sv
// Saturating interval counter with threshold flags for the MPPT decoder.
module mppt_timer
  import mppt_pkg::*;
#(
  parameter int unsigned W_CNT    = DEF_W_CNT,
  parameter int unsigned T_START  = DEF_T_START,
  parameter int unsigned T_PERIOD = DEF_T_PERIOD
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  output logic [1:0] o_flag
);

  localparam logic [W_CNT-1:0] L_START  = W_CNT'(T_START);
  localparam logic [W_CNT-1:0] L_PERIOD = W_CNT'(T_PERIOD);

  logic [W_CNT-1:0] r_cnt;

  // Counter: synchronous clear wins, otherwise count up and stick at all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Flags are pure compares on the registered count.
  always_comb begin
    o_flag              = 2'b00;
    o_flag[FLAG_START]  = (r_cnt >= L_START);
    o_flag[FLAG_PERIOD] = (r_cnt >= L_PERIOD);
  end

endmodule

// File: rtl/mppt_dp.sv
// Perturb-and-observe MPPT datapath: sample V/I, form power, choose the
// perturbation direction and step the clamped converter duty word.
module mppt_dp
  import mppt_pkg::*;
#(
  parameter int unsigned W_ADC     = DEF_W_ADC,
  parameter int unsigned W_DUTY    = DEF_W_DUTY,
  parameter int unsigned W_CNT     = DEF_W_CNT,
  parameter int unsigned T_START   = DEF_T_START,
  parameter int unsigned T_PERIOD  = DEF_T_PERIOD,
  parameter int unsigned DUTY_INIT = DEF_DUTY_INIT,
  parameter int unsigned DUTY_MIN  = DEF_DUTY_MIN,
  parameter int unsigned DUTY_MAX  = DEF_DUTY_MAX,
  parameter int unsigned DUTY_STEP = DEF_DUTY_STEP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           en,
  input  logic                 rst_ci,
  input  logic [W_ADC-1:0]     v_adc,
  input  logic [W_ADC-1:0]     i_adc,
  output logic [1:0]           flag_o,
  output logic [W_DUTY-1:0]    duty,
  output logic                 dir,
  output logic [2*W_ADC-1:0]   p_out
);

  // One bit wider than the duty word so the clamp sees overflow/borrow.
  localparam logic [W_DUTY:0]   L_STEP = (W_DUTY+1)'(DUTY_STEP);
  localparam logic [W_DUTY:0]   L_MAX  = (W_DUTY+1)'(DUTY_MAX);
  localparam logic [W_DUTY:0]   L_MIN  = (W_DUTY+1)'(DUTY_MIN);
  localparam logic [W_DUTY-1:0] L_INIT = W_DUTY'(DUTY_INIT);

  logic [W_ADC-1:0]   r_v;
  logic [W_ADC-1:0]   r_i;
  logic [2*W_ADC-1:0] r_p;
  logic [2*W_ADC-1:0] r_p_prev;
  logic [W_ADC-1:0]   r_v_prev;
  logic               r_step_en;
  logic               r_dir;
  logic [W_DUTY-1:0]  r_duty;

  logic [W_DUTY:0]    w_sum;
  logic [W_DUTY:0]    w_diff;
  logic               w_hit_max;
  logic               w_hit_min;
  logic               w_unused_v_prev;

  mppt_timer #(
    .W_CNT    (W_CNT),
    .T_START  (T_START),
    .T_PERIOD (T_PERIOD)
  ) u_timer (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (rst_ci),
    .o_flag (flag_o)
  );

  // Widened step results and clamp detection for the update stage.
  always_comb begin
    w_sum     = {1'b0, r_duty} + L_STEP;
    w_diff    = {1'b0, r_duty} - L_STEP;
    w_hit_max = (w_sum >= L_MAX);
    w_hit_min = w_diff[W_DUTY] || (w_diff <= L_MIN);
  end

  // Stage registers; each strobe touches only its own stage's state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v       <= '0;
      r_i       <= '0;
      r_p       <= '0;
      r_p_prev  <= '0;
      r_v_prev  <= '0;
      r_step_en <= 1'b0;
      r_dir     <= 1'b1;
      r_duty    <= L_INIT;
    end else begin
      if (en[EN_SAMPLE]) begin
        r_v <= v_adc;
        r_i <= i_adc;
      end
      if (en[EN_POWER]) begin
        r_p <= {{W_ADC{1'b0}}, r_v} * {{W_ADC{1'b0}}, r_i};
      end
      if (en[EN_DECIDE]) begin
        r_step_en <= (r_p != r_p_prev);
        if (r_p < r_p_prev) begin
          r_dir <= ~r_dir;
        end
        r_p_prev <= r_p;
        r_v_prev <= r_v;
      end
      // Uses pre-edge dir/step_en; a clamp bounce overrides a same-edge flip.
      if (en[EN_UPDATE] && r_step_en) begin
        if (r_dir) begin
          if (w_hit_max) begin
            r_duty <= L_MAX[W_DUTY-1:0];
            r_dir  <= 1'b0;
          end else begin
            r_duty <= w_sum[W_DUTY-1:0];
          end
        end else begin
          if (w_hit_min) begin
            r_duty <= L_MIN[W_DUTY-1:0];
            r_dir  <= 1'b1;
          end else begin
            r_duty <= w_diff[W_DUTY-1:0];
          end
        end
      end
    end
  end

  // Previous voltage is kept for future incremental-conductance use only.
  assign w_unused_v_prev = ^r_v_prev;

  assign duty  = r_duty;
  assign dir   = r_dir;
  assign p_out = r_p;

endmodule

// File: tb/tb_mppt_dp.sv
// Self-checking bench for mppt_dp with an iteration-level P&O reference model.
module tb_mppt_dp;

  logic        clk;
  logic        rst;
  logic [3:0]  en;
  logic        rst_ci;
  logic [11:0] v_adc;
  logic [11:0] i_adc;
  logic [1:0]  flag_o;
  logic [9:0]  duty;
  logic        dir;
  logic [23:0] p_out;

  int n_pass;
  int n_total;

  // Reference model state: one P&O iteration at a time.
  int          m_duty;
  bit          m_dir;
  longint      m_pprev;
  longint      m_p;

  mppt_dp u_dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .rst_ci (rst_ci),
    .v_adc  (v_adc),
    .i_adc  (i_adc),
    .flag_o (flag_o),
    .duty   (duty),
    .dir    (dir),
    .p_out  (p_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_duty  = 512;
    m_dir   = 1'b1;
    m_pprev = 0;
    m_p     = 0;
  endtask

  // Perturb and observe: flip on power drop, step only if power changed.
  task automatic model_iter(input int v, input int i);
    m_p = longint'(v) * longint'(i);
    if (m_p < m_pprev) m_dir = ~m_dir;
    if (m_p != m_pprev) begin
      if (m_dir) begin
        m_duty = (m_duty + 4 > 960) ? 960 : m_duty + 4;
        if (m_duty == 960) m_dir = 1'b0;
      end else begin
        m_duty = (m_duty - 4 < 64) ? 64 : m_duty - 4;
        if (m_duty == 64) m_dir = 1'b1;
      end
    end
    m_pprev = m_p;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst    = 1'b1;
    en     = 4'b0000;
    rst_ci = 1'b0;
    v_adc  = '0;
    i_adc  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_iter(input logic [11:0] v, input logic [11:0] i);
    @(negedge clk);
    v_adc = v;
    i_adc = i;
    en    = 4'b0001;
    @(negedge clk);
    en = 4'b0010;
    @(negedge clk);
    en = 4'b0100;
    @(negedge clk);
    en = 4'b1000;
    @(negedge clk);
    en = 4'b0000;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 4'b0000;
    rst_ci = 1'b0;
    #1;
    n_total++;
    if (duty !== 10'd512) $display("FAIL reset_duty got %0d want 512", duty);
    else n_pass++;
    n_total++;
    if (dir !== 1'b1) $display("FAIL reset_dir got %0b want 1", dir);
    else n_pass++;
    n_total++;
    if (p_out !== 24'd0) $display("FAIL reset_p got %0d want 0", p_out);
    else n_pass++;
    n_total++;
    if (flag_o !== 2'b00) $display("FAIL reset_flag got %b want 00", flag_o);
    else n_pass++;
  endtask

  task automatic test_timer();
    logic [1:0] exp;
    // Still in reset from test_reset; release on a falling edge.
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      @(posedge clk);
      #1;
      exp = {(k >= 100), (k >= 8)};
      n_total++;
      if (flag_o !== exp) $display("FAIL timer_flag edge %0d got %b want %b", k, flag_o, exp);
      else n_pass++;
    end
    @(negedge clk);
    rst_ci = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (flag_o !== 2'b00) $display("FAIL timer_clear got %b want 00", flag_o);
    else n_pass++;
    rst_ci = 1'b0;
    // Past the 16-bit range: a wrapping counter would read a small value here.
    repeat (65540) @(posedge clk);
    #1;
    n_total++;
    if (flag_o !== 2'b11) $display("FAIL timer_saturate got %b want 11", flag_o);
    else n_pass++;
  endtask

  task automatic test_first_step();
    logic [11:0] vs [3];
    logic [11:0] is [3];
    vs = '{12'd100, 12'd100, 12'd100};
    is = '{12'd50, 12'd40, 12'd40};
    apply_reset();
    for (int n = 0; n < 3; n++) begin
      do_iter(vs[n], is[n]);
      model_iter(int'(vs[n]), int'(is[n]));
      n_total++;
      if (p_out !== 24'(m_p)) $display("FAIL step%0d_p got %0d want %0d", n, p_out, m_p);
      else n_pass++;
      n_total++;
      if (dir !== m_dir) $display("FAIL step%0d_dir got %0b want %0b", n, dir, m_dir);
      else n_pass++;
      n_total++;
      if (duty !== 10'(m_duty)) $display("FAIL step%0d_duty got %0d want %0d", n, duty, m_duty);
      else n_pass++;
    end
    // Hard anchors for the three scenarios independent of the model.
    n_total++;
    if (duty !== 10'd512 || dir !== 1'b0)
      $display("FAIL equal_power got duty %0d dir %0b want 512 0", duty, dir);
    else n_pass++;
  endtask

  task automatic test_clamp();
    bit seen_max;
    bit seen_min;
    seen_max = 0;
    seen_min = 0;
    apply_reset();
    // Strictly rising power drives duty up into DUTY_MAX, then down to DUTY_MIN.
    for (int k = 1; k <= 340; k++) begin
      do_iter(12'd100, 12'(k));
      model_iter(100, k);
      n_total++;
      if (duty !== 10'(m_duty) || dir !== m_dir)
        $display("FAIL clamp_iter%0d got duty %0d dir %0b want %0d %0b",
                 k, duty, dir, m_duty, m_dir);
      else n_pass++;
      if (m_duty == 960) seen_max = 1;
      if (m_duty == 64) seen_min = 1;
      if (k == 112) begin
        n_total++;
        if (duty !== 10'd960 || dir !== 1'b0)
          $display("FAIL clamp_max got duty %0d dir %0b want 960 0", duty, dir);
        else n_pass++;
      end
      if (k == 336) begin
        n_total++;
        if (duty !== 10'd64 || dir !== 1'b1)
          $display("FAIL clamp_min got duty %0d dir %0b want 64 1", duty, dir);
        else n_pass++;
      end
    end
    n_total++;
    if (!(seen_max && seen_min)) $display("FAIL clamp_reached got %0b%0b want 11", seen_max, seen_min);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [11:0] v;
    logic [11:0] i;
    v = 12'd0;
    i = 12'd0;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(3, 0) != 0) begin
        v = 12'($urandom_range(4095, 0));
        i = 12'($urandom_range(4095, 0));
      end
      do_iter(v, i);
      model_iter(int'(v), int'(i));
      n_total++;
      if (p_out !== 24'(m_p) || duty !== 10'(m_duty) || dir !== m_dir)
        $display("FAIL random%0d got p %0d duty %0d dir %0b want %0d %0d %0b",
                 n, p_out, duty, dir, m_p, m_duty, m_dir);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    do_iter(12'd100, 12'd50);
    model_iter(100, 50);
    repeat (120) @(negedge clk);
    // Partial iteration: sample and power, then reset before decide.
    v_adc = 12'd100;
    i_adc = 12'd40;
    en    = 4'b0001;
    @(negedge clk);
    en = 4'b0010;
    @(negedge clk);
    en  = 4'b0000;
    rst = 1'b1;
    #1;
    n_total++;
    if (duty !== 10'd512 || dir !== 1'b1 || flag_o !== 2'b00 || p_out !== 24'd0)
      $display("FAIL reset_mid got duty %0d dir %0b flag %b p %0d want 512 1 00 0",
               duty, dir, flag_o, p_out);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    do_iter(12'd100, 12'd50);
    model_iter(100, 50);
    n_total++;
    if (duty !== 10'd516 || dir !== 1'b1 || p_out !== 24'd5000)
      $display("FAIL reset_restart got duty %0d dir %0b p %0d want 516 1 5000",
               duty, dir, p_out);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    en      = 4'b0000;
    rst_ci  = 1'b0;
    v_adc   = '0;
    i_adc   = '0;
    model_reset();
    test_reset();
    test_timer();
    test_first_step();
    test_clamp();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
